stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control FSM and time base for the two-digit seven-segment seconds timer. It turns three button inputs into start/stop, lap and clear commands and generates the 1 s tick enable. It keeps the 00-99 BCD count and supplies the tens/ones BCD values that the downstream segment decoder displays. It replaces the free-running divider and gated-clock counting with a single-clock enable scheme.

Parameters:
TICK_DIV, 50000000, clk cycles per count tick; legal range is at least 2.
DEB_CYCLES, 1000000, stable cycles required by the debounce filter; used only with STOPWATCH_DEBOUNCE_EN.

Ports:
clk  in  1  system clock; every flop is on its rising edge.
rst_n  in  1  asynchronous active-low reset.
btn_ss  in  1  start/stop button, active-high, asynchronous to clk.
btn_lap  in  1  lap button, active-high, asynchronous.
btn_clr  in  1  clear button, active-high, asynchronous.
tick_en  out  1  one-cycle pulse on each count increment.
bcd_tens  out  4  displayed tens digit, 0-9.
bcd_ones  out  4  displayed ones digit, 0-9.
running  out  1  high in RUN or LAP.
lap_hold  out  1  high in LAP (display frozen).
wrap  out  1  one-cycle pulse when the count rolls 99->00.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, prescaler=0, count=00, lap latch=00.
  - All outputs 0; synchronizer and edge flops 0.
- Input path, per button: 2-flop synchronizer, then a third flop. cmd = s2 & ~s3.
  - A button sampled high at edge k updates state at edge k+2.
  - Holding a button produces exactly one command.
- Command priority when several commands arrive in the same cycle: clr > ss > lap. Lower-priority commands in that cycle are dropped.
- States and transitions (a command not listed is ignored):
  - IDLE: ss -> RUN.
  - RUN: ss -> PAUSE; lap -> LAP and load the lap latch with the current count in the same cycle.
  - LAP: ss -> PAUSE and the display returns to the live count; lap -> RUN and the display returns live.
  - PAUSE: ss -> RUN; clr -> IDLE.
  - clr in RUN or LAP is ignored. clr in IDLE is a no-op.
- Prescaler:
  - Counts only in RUN/LAP.
  - In PAUSE it holds its value, so resume preserves the partial second.
  - Cleared on entry to IDLE.
  - When prescaler == TICK_DIV-1 in RUN/LAP: prescaler <= 0, and tick_en=1 for that cycle.
  - First tick occurs TICK_DIV cycles after entering RUN from IDLE.
- Count (BCD, registered, updates on the edge that ends the tick_en cycle):
  - ones 9->0 with tens+1.
  - 99->00, with wrap=1 in the same cycle as tick_en.
  - tick_en and wrap are registered and coincident.
  - Counting continues while in LAP.
- Display outputs:
  - bcd_tens/bcd_ones = lap latch when in LAP, else the live count.
  - Registered; they change one cycle after the count or state changes.
- Entering IDLE via clr: count=00 and lap latch=00 on the transition edge; outputs read 00 on the next cycle.
- An ss command in the same cycle as a tick: the tick still applies to the count, then the state changes.
- A tick in the cycle a lap command is accepted: the latch captures the pre-increment count.
- Reset mid-operation: immediate return to the reset values. No command is remembered.

Optional Feature:
Macro: STOPWATCH_DEBOUNCE_EN.
- Defined:
  - Each synchronized button feeds a counter that must see DEB_CYCLES consecutive identical samples before the filtered level (the input to the s3/edge stage) changes.
  - Glitches shorter than DEB_CYCLES produce no command.
  - Command latency becomes k+2+DEB_CYCLES edges.
- Not defined:
  - No filter logic is instantiated and DEB_CYCLES is unused.
  - The latency is exactly as described in Behaviour.

Test Plan:
1. Reset checks, TICK_DIV=4 for all: rst_n=0 while buttons toggle -> all outputs 0; rst_n=1 with no button -> outputs stay 0 for 20 cycles.
2. Run and tick spacing: pulse btn_ss for 3 cycles -> running=1 two edges later; tick_en every 4th cycle; bcd_ones 0,1,2 with ticks; a 10th tick gives tens=1 ones=0.
3. Wrap: run to 99, next tick -> bcd 00, wrap=1 coincident with tick_en for exactly one cycle, running stays 1.
4. Lap: lap command at count 12 -> lap_hold=1 and display frozen at 12 across 3 ticks; second lap -> lap_hold=0 and display shows 15.
5. Pause and clear:
   - At count 37, ss -> running=0 and count holds 37 for 40 cycles.
   - clr -> IDLE and display 00.
   - Separately, clr during RUN -> ignored, count keeps advancing.
   - ss resumed after a pause at prescaler=2 -> next tick 2 cycles after RUN re-entry.
6. Priority and async reset:
   - clr+ss in the same cycle in PAUSE -> IDLE (not RUN).
   - rst_n pulse low mid-RUN at count 55 -> immediately 00 and running=0.
   - With STOPWATCH_DEBOUNCE_EN and DEB_CYCLES=8: a 5-cycle btn_ss glitch -> no state change; a 12-cycle press -> RUN.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and display/status outputs of the stopwatch controller.
// The master side drives the buttons; the slave side is the controller.
interface stopwatch_ctrl_if;
    logic       btn_ss;
    logic       btn_lap;
    logic       btn_clr;
    logic       tick_en;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       running;
    logic       lap_hold;
    logic       wrap;

    modport master (
        output btn_ss, btn_lap, btn_clr,
        input  tick_en, bcd_tens, bcd_ones, running, lap_hold, wrap
    );

    modport slave (
        input  btn_ss, btn_lap, btn_clr,
        output tick_en, bcd_tens, bcd_ones, running, lap_hold, wrap
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM, 1 s tick prescaler and 00-99 BCD seconds count.
// Optional button debounce filter is enabled with the macro STOPWATCH_DEBOUNCE_EN.
module stopwatch_ctrl #(
    parameter int TICK_DIV   = 50000000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    stopwatch_ctrl_if.slave  bus
);

    localparam int              PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LAP   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            if (v[7:4] == 4'd9) begin
                r[7:4] = 4'd0;
            end else begin
                r[7:4] = v[7:4] + 4'd1;
            end
        end else begin
            r[7:4] = v[7:4];
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

    // bit 2 = clear, bit 1 = start/stop, bit 0 = lap
    logic [2:0]     btn_s;
    logic [2:0]     sync1_r;
    logic [2:0]     sync2_r;
    logic [2:0]     level_s;
    logic [2:0]     edge_r;
    logic [2:0]     cmd_s;
    logic           cmd_clr_s;
    logic           cmd_ss_s;
    logic           cmd_lap_s;

    state_t         state_r;
    state_t         state_nxt_s;
    logic           lap_load_s;
    logic           clear_s;
    logic           active_s;
    logic           tick_s;

    logic [PW-1:0]  presc_r;
    logic [7:0]     cnt_r;
    logic [7:0]     lap_r;
    logic [7:0]     disp_r;
    logic           tick_en_r;
    logic           wrap_r;
    logic           running_r;
    logic           lap_hold_r;

    assign btn_s = {bus.btn_clr, bus.btn_ss, bus.btn_lap};

    // Two-flop synchronizer for the asynchronous buttons
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= btn_s;
            sync2_r <= sync1_r;
        end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int            DW      = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);

    logic [2:0]    filt_r;
    logic [DW-1:0] deb_cnt_r [3];

    // Level only follows the input after DEB_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_r[i] <= {DW{1'b0}};
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] == filt_r[i]) begin
                    deb_cnt_r[i] <= {DW{1'b0}};
                end else if (deb_cnt_r[i] == DEB_MAX) begin
                    filt_r[i]    <= sync2_r[i];
                    deb_cnt_r[i] <= {DW{1'b0}};
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1'b1);
                end
            end
        end
    end

    assign level_s = filt_r;
`else
    assign level_s = sync2_r;
`endif

    // Edge flop: one command per press regardless of hold time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_r <= 3'b000;
        end else begin
            edge_r <= level_s;
        end
    end

    assign cmd_s     = level_s & ~edge_r;
    assign cmd_clr_s = cmd_s[2];
    assign cmd_ss_s  = cmd_s[1] & ~cmd_s[2];
    assign cmd_lap_s = cmd_s[0] & ~cmd_s[1] & ~cmd_s[2];

    assign active_s  = (state_r == ST_RUN) || (state_r == ST_LAP);
    assign tick_s    = active_s && (presc_r == PRESC_MAX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; clr is honoured only from PAUSE
    always_comb begin
        state_nxt_s = state_r;
        lap_load_s  = 1'b0;
        clear_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_ss_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cmd_ss_s) begin
                    state_nxt_s = ST_PAUSE;
                end else if (cmd_lap_s) begin
                    state_nxt_s = ST_LAP;
                    lap_load_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_LAP: begin
                if (cmd_ss_s) begin
                    state_nxt_s = ST_PAUSE;
                end else if (cmd_lap_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_LAP;
                end
            end
            ST_PAUSE: begin
                if (cmd_clr_s) begin
                    state_nxt_s = ST_IDLE;
                    clear_s     = 1'b1;
                end else if (cmd_ss_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Prescaler holds in PAUSE so a resume keeps the partial second
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= {PW{1'b0}};
        end else if (clear_s || tick_s) begin
            presc_r <= {PW{1'b0}};
        end else if (active_s) begin
            presc_r <= presc_r + PW'(1'b1);
        end else begin
            presc_r <= presc_r;
        end
    end

    // Tick and wrap pulses; count is still pre-increment when tick_s is seen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_en_r <= 1'b0;
            wrap_r    <= 1'b0;
        end else begin
            tick_en_r <= tick_s;
            wrap_r    <= tick_s && (cnt_r == 8'h99);
        end
    end

    // Live count advances at the end of the tick_en cycle; lap latch snapshots it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 8'h00;
            lap_r <= 8'h00;
        end else if (clear_s) begin
            cnt_r <= 8'h00;
            lap_r <= 8'h00;
        end else begin
            if (tick_en_r) begin
                cnt_r <= bcd_inc(cnt_r);
            end else begin
                cnt_r <= cnt_r;
            end
            if (lap_load_s) begin
                lap_r <= cnt_r;
            end else begin
                lap_r <= lap_r;
            end
        end
    end

    // Registered display and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_r     <= 8'h00;
            running_r  <= 1'b0;
            lap_hold_r <= 1'b0;
        end else begin
            disp_r     <= (state_r == ST_LAP) ? lap_r : cnt_r;
            running_r  <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_LAP);
            lap_hold_r <= (state_nxt_s == ST_LAP);
        end
    end

    assign bus.tick_en  = tick_en_r;
    assign bus.wrap     = wrap_r;
    assign bus.bcd_tens = disp_r[7:4];
    assign bus.bcd_ones = disp_r[3:0];
    assign bus.running  = running_r;
    assign bus.lap_hold = lap_hold_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed scoreboard bench for stopwatch_ctrl with TICK_DIV=4 (DEB_CYCLES=8 when
// STOPWATCH_DEBOUNCE_EN is defined).
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   rel    = 0;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(
        .TICK_DIV   (4),
        .DEB_CYCLES (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sw_if)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rel++;
        end
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        int m;
        m = n % 100;
        return {4'(m / 10), 4'(m % 10)};
    endfunction

    function automatic logic [15:0] pack(input logic t, input logic w, input logic r,
                                         input logic l, input logic [7:0] d);
        return {4'h0, t, w, r, l, d};
    endfunction

    function automatic logic [15:0] obs();
        return {4'h0, sw_if.tick_en, sw_if.wrap, sw_if.running, sw_if.lap_hold,
                sw_if.bcd_tens, sw_if.bcd_ones};
    endfunction

    task automatic expect_push(input string tag, input logic [15:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic compare(input logic [15:0] o);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=%h", o);
        end else begin
            e = sb.pop_front();
            checks++;
            assert (o === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
            end
        end
    endtask

    // Fields: tick_en, wrap, running, lap_hold, displayed value (decimal)
    task automatic chk(input string tag, input logic t, input logic w, input logic r,
                       input logic l, input int d);
        expect_push(tag, pack(t, w, r, l, to_bcd(d)));
        compare(obs());
    endtask

    task automatic set_btn(input logic c, input logic s, input logic l);
        sw_if.btn_clr = c;
        sw_if.btn_ss  = s;
        sw_if.btn_lap = l;
    endtask

    task automatic start_run();
        rst_n = 1'b0;
        set_btn(1'b0, 1'b0, 1'b0);
        step(2);
        rst_n = 1'b1;
        step(1);
        sw_if.btn_ss = 1'b1;
        step(2);
        expect_push("ss_latency_early", 16'h0000);
        compare({15'h0000, sw_if.running});
        step(1);
        sw_if.btn_ss = 1'b0;
        expect_push("ss_to_run", 16'h0001);
        compare({15'h0000, sw_if.running});
        rel = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        set_btn(1'b0, 1'b0, 1'b0);

        // Reset holds everything at zero while buttons toggle
        for (int i = 0; i < 6; i++) begin
            set_btn(i[1], i[0], ~i[0]);
            step(1);
            chk("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        end
        set_btn(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("idle_quiet", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        end

`ifdef STOPWATCH_DEBOUNCE_EN
        // Short glitch is filtered, long press starts the run
        sw_if.btn_ss = 1'b1;
        step(5);
        sw_if.btn_ss = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("deb_glitch", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        end
        sw_if.btn_ss = 1'b1;
        step(10);
        chk("deb_press_early", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step(1);
        chk("deb_press_run", 1'b0, 1'b0, 1'b1, 1'b0, 0);
        step(1);
        sw_if.btn_ss = 1'b0;
`else
        // Tick spacing, BCD carry and 99->00 wrap
        start_run();
        for (int i = 1; i <= 410; i++) begin
            step(1);
            chk("run_seq", (i % 4 == 0), (i == 400), 1'b1, 1'b0, (i < 2) ? 0 : (i - 2) / 4);
        end

        // Lap at 12: frozen across three ticks, second lap shows live 15
        start_run();
        step(47);
        chk("pre_lap", 1'b0, 1'b0, 1'b1, 1'b0, 11);
        sw_if.btn_lap = 1'b1;
        step(3);
        sw_if.btn_lap = 1'b0;
        chk("lap_enter", 1'b0, 1'b0, 1'b1, 1'b1, 12);
        while (rel < 60) begin
            step(1);
            chk("lap_frozen", (rel % 4 == 0), 1'b0, 1'b1, 1'b1, 12);
        end
        sw_if.btn_lap = 1'b1;
        step(1);
        sw_if.btn_lap = 1'b0;
        chk("lap_exit_wait", 1'b0, 1'b0, 1'b1, 1'b1, 12);
        step(1);
        chk("lap_exit_wait", 1'b0, 1'b0, 1'b1, 1'b1, 12);
        step(1);
        chk("lap_exit_state", 1'b0, 1'b0, 1'b1, 1'b0, 12);
        step(1);
        chk("lap_exit_live", 1'b1, 1'b0, 1'b1, 1'b0, 15);

        // Pause at 37, resume keeps partial second, ss with tick, then clear
        start_run();
        step(147);
        sw_if.btn_ss = 1'b1;
        step(1);
        sw_if.btn_ss = 1'b0;
        step(2);
        chk("pause_enter", 1'b0, 1'b0, 1'b0, 1'b0, 37);
        for (int i = 0; i < 40; i++) begin
            step(1);
            chk("pause_hold", 1'b0, 1'b0, 1'b0, 1'b0, 37);
        end
        sw_if.btn_ss = 1'b1;
        step(1);
        sw_if.btn_ss = 1'b0;
        step(2);
        chk("resume_run", 1'b0, 1'b0, 1'b1, 1'b0, 37);
        step(1);
        chk("resume_partial", 1'b0, 1'b0, 1'b1, 1'b0, 37);
        step(1);
        chk("resume_tick", 1'b1, 1'b0, 1'b1, 1'b0, 37);
        step(1);
        chk("resume_after", 1'b0, 1'b0, 1'b1, 1'b0, 37);
        sw_if.btn_ss = 1'b1;
        step(1);
        sw_if.btn_ss = 1'b0;
        chk("resume_count", 1'b0, 1'b0, 1'b1, 1'b0, 38);
        step(1);
        chk("ss_tick_pre", 1'b0, 1'b0, 1'b1, 1'b0, 38);
        step(1);
        chk("ss_tick_same", 1'b1, 1'b0, 1'b0, 1'b0, 38);
        step(1);
        chk("ss_tick_after", 1'b0, 1'b0, 1'b0, 1'b0, 38);
        step(1);
        chk("ss_tick_applied", 1'b0, 1'b0, 1'b0, 1'b0, 39);
        sw_if.btn_clr = 1'b1;
        step(1);
        sw_if.btn_clr = 1'b0;
        step(2);
        chk("clr_edge", 1'b0, 1'b0, 1'b0, 1'b0, 39);
        step(1);
        chk("clr_idle", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("idle_after_clr", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        end

        // clr ignored in RUN, then clr+ss in PAUSE goes to IDLE
        start_run();
        step(10);
        sw_if.btn_clr = 1'b1;
        step(1);
        sw_if.btn_clr = 1'b0;
        step(9);
        chk("clr_in_run", 1'b1, 1'b0, 1'b1, 1'b0, 4);
        sw_if.btn_ss = 1'b1;
        step(1);
        sw_if.btn_ss = 1'b0;
        step(2);
        chk("pause2_enter", 1'b0, 1'b0, 1'b0, 1'b0, 5);
        step(7);
        set_btn(1'b1, 1'b1, 1'b0);
        step(1);
        set_btn(1'b0, 1'b0, 1'b0);
        step(2);
        chk("prio_state", 1'b0, 1'b0, 1'b0, 1'b0, 5);
        step(1);
        chk("prio_idle", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk("prio_not_run", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        end

        // Asynchronous reset mid-run at 55
        start_run();
        step(222);
        chk("pre_reset", 1'b0, 1'b0, 1'b1, 1'b0, 55);
        rst_n = 1'b0;
        #1;
        chk("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step(2);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
